// File: rtl/flow_ctrl_pkg.sv
// rtl/flow_ctrl_pkg.sv - shared types and constants for the flow route scheduler
package flow_ctrl_pkg;

  localparam int MIX_SEL_W        = 3;
  localparam int NUM_MIX_PER_SIDE = 6;
  localparam int NUM_SRC          = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FLOW,
    ST_FLUSH,
    ST_DONE
  } flow_state_e;

  // Mixer indices 6 and 7 have no physical mixer behind them.
  function automatic logic mix_legal(input logic [MIX_SEL_W-1:0] mix);
    return mix < MIX_SEL_W'(NUM_MIX_PER_SIDE);
  endfunction

endpackage

// File: rtl/flow_phase_timer.sv
// rtl/flow_phase_timer.sv - load/decrement phase counter that saturates at zero
module flow_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Load wins over decrement; the count stops at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/flow_route_scheduler.sv
// rtl/flow_route_scheduler.sv - round-robin job sequencer for the merge switch; FLUSH phase built only with FLOW_ROUTE_FLUSH_EN
import flow_ctrl_pkg::*;

module flow_route_scheduler #(
  parameter int SETTLE_CYC = 4,
  parameter int FLOW_CYC   = 16,
  parameter int FLUSH_CYC  = 8,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            req_valid,
  output logic [NUM_SRC-1:0]            req_ready,
  input  logic [NUM_SRC*MIX_SEL_W-1:0]  req_mix,
  input  logic [NUM_SRC-1:0]            req_heat,
  input  logic [NUM_SRC-1:0]            req_filt,
  output logic                          route_src,
  output logic [MIX_SEL_W-1:0]          mix_sel,
  output logic                          heat_sel,
  output logic                          filt_sel,
  output logic                          cfg_valid,
  output logic                          flow_en,
  output logic                          flush_en,
  output logic                          done,
  output logic                          done_id,
  output logic                          done_err
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] FLOW_LOAD   = CNT_W'(FLOW_CYC - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYC - 1);

  flow_state_e          state, state_n;
  logic                 last_grant, last_grant_n;
  logic                 winner;
  logic                 accept;
  logic                 route_src_n;
  logic [MIX_SEL_W-1:0] mix_sel_n;
  logic                 heat_sel_n, filt_sel_n;
  logic                 err_q, err_n;
  logic                 tmr_load, tmr_dec, tmr_expired;
  logic [CNT_W-1:0]     tmr_val;

  // Round-robin pick: a lone requester wins, a tie goes to the side not served last.
  always_comb begin
    winner = 1'b0;
    if (req_valid == 2'b11) begin
      winner = ~last_grant;
    end else if (req_valid[1]) begin
      winner = 1'b1;
    end
    req_ready = '0;
    if ((state == ST_IDLE) && !rst && (req_valid != '0)) begin
      req_ready = winner ? 2'b10 : 2'b01;
    end
    accept = (req_ready != '0);
  end

  // Next-state and per-job latch values.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    route_src_n  = route_src;
    mix_sel_n    = mix_sel;
    heat_sel_n   = heat_sel;
    filt_sel_n   = filt_sel;
    err_n        = err_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          route_src_n  = winner;
          last_grant_n = winner;
          mix_sel_n    = winner ? req_mix[2*MIX_SEL_W-1:MIX_SEL_W] : req_mix[MIX_SEL_W-1:0];
          heat_sel_n   = req_heat[winner];
          filt_sel_n   = req_filt[winner];
          if (mix_legal(mix_sel_n)) begin
            err_n   = 1'b0;
            state_n = ST_SETTLE;
          end else begin
            err_n   = 1'b1;
            state_n = ST_DONE;
          end
        end
      end
      ST_SETTLE: if (tmr_expired) state_n = ST_FLOW;
      ST_FLOW: begin
        if (tmr_expired) begin
`ifdef FLOW_ROUTE_FLUSH_EN
          state_n = ST_FLUSH;
`else
          state_n = ST_DONE;
`endif
        end
      end
      ST_FLUSH: if (tmr_expired) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Every phase change reloads the shared timer with the entered phase's length.
  always_comb begin
    tmr_load = (state_n != state);
    tmr_dec  = !tmr_load;
    case (state_n)
      ST_SETTLE: tmr_val = SETTLE_LOAD;
      ST_FLOW:   tmr_val = FLOW_LOAD;
      ST_FLUSH:  tmr_val = FLUSH_LOAD;
      default:   tmr_val = '0;
    endcase
  end

  flow_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .expired  (tmr_expired)
  );

  // State, job latches and registered valve/status outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
      route_src  <= 1'b0;
      mix_sel    <= '0;
      heat_sel   <= 1'b0;
      filt_sel   <= 1'b0;
      cfg_valid  <= 1'b0;
      flow_en    <= 1'b0;
      flush_en   <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      err_q      <= err_n;
      route_src  <= route_src_n;
      mix_sel    <= mix_sel_n;
      heat_sel   <= heat_sel_n;
      filt_sel   <= filt_sel_n;
      cfg_valid  <= (state_n == ST_SETTLE) || (state_n == ST_FLOW) || (state_n == ST_FLUSH);
      flow_en    <= (state_n == ST_FLOW);
`ifdef FLOW_ROUTE_FLUSH_EN
      flush_en   <= (state_n == ST_FLUSH);
`else
      flush_en   <= 1'b0;
`endif
      done       <= (state_n == ST_DONE);
      done_id    <= (state_n == ST_DONE) && route_src_n;
      done_err   <= (state_n == ST_DONE) && err_n;
    end
  end

endmodule

// File: tb/tb_flow_route_scheduler.sv
// tb/tb_flow_route_scheduler.sv - directed self-checking bench for flow_route_scheduler (honours FLOW_ROUTE_FLUSH_EN)
module tb_flow_route_scheduler;

  localparam int S     = 4;
  localparam int F     = 16;
  localparam int FLUSH = 8;
`ifdef FLOW_ROUTE_FLUSH_EN
  localparam int U = FLUSH;
`else
  localparam int U = 0;
`endif
  localparam int JOB = 1 + S + F + U;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [5:0] req_mix = '0;
  logic [1:0] req_heat = '0;
  logic [1:0] req_filt = '0;
  logic       route_src;
  logic [2:0] mix_sel;
  logic       heat_sel, filt_sel, cfg_valid, flow_en, flush_en, done, done_id, done_err;

  int n_assert = 0;
  int n_fail   = 0;
  int k;

  flow_route_scheduler #(
    .SETTLE_CYC (S),
    .FLOW_CYC   (F),
    .FLUSH_CYC  (FLUSH),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mix   (req_mix),
    .req_heat  (req_heat),
    .req_filt  (req_filt),
    .route_src (route_src),
    .mix_sel   (mix_sel),
    .heat_sel  (heat_sel),
    .filt_sel  (filt_sel),
    .cfg_valid (cfg_valid),
    .flow_en   (flow_en),
    .flush_en  (flush_en),
    .done      (done),
    .done_id   (done_id),
    .done_err  (done_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // reset values
    tick();
    tick();
    chk("rst_cfg_valid", 32'(cfg_valid), 0);
    chk("rst_flow_en", 32'(flow_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mix_sel", 32'(mix_sel), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    rst = 1'b0;
    #1;

    // single job from source 0: mix=2 heat=1 filt=0
    req_mix = {3'd0, 3'd2};
    req_heat = 2'b01;
    req_filt = 2'b00;
    req_valid = 2'b01;
    #1;
    chk("t1_ready", 32'(req_ready), 1);
    for (int c = 1; c <= JOB + 1; c++) begin
      tick();
      if (c == 1) begin
        req_valid = '0;
        chk("t1_route", 32'(route_src), 0);
        chk("t1_mix", 32'(mix_sel), 2);
        chk("t1_heat", 32'(heat_sel), 1);
        chk("t1_filt", 32'(filt_sel), 0);
      end
      chk("t1_cfg_valid", 32'(cfg_valid), 32'(c >= 1 && c <= JOB - 1));
      chk("t1_flow_en", 32'(flow_en), 32'(c >= 1 + S && c <= S + F));
      chk("t1_flush_en", 32'(flush_en), 32'(c >= 1 + S + F && c <= S + F + U));
      chk("t1_done", 32'(done), 32'(c == JOB));
      if (c == JOB) begin
        chk("t1_done_id", 32'(done_id), 0);
        chk("t1_done_err", 32'(done_err), 0);
      end
    end

    // both sources continuously valid: grants alternate 0,1,0,1
    do_reset();
    req_mix = {3'd5, 3'd1};
    req_heat = '0;
    req_filt = '0;
    req_valid = 2'b11;
    #1;
    for (int j = 0; j < 4; j++) begin
      k = 0;
      while (req_ready == 2'b00 && k < 60) begin
        tick();
        k++;
        chk("t2_never_both", 32'(req_ready == 2'b11), 0);
      end
      chk("t2_grant", 32'(req_ready), (j % 2 == 0) ? 1 : 2);
      tick();
      chk("t2_route", 32'(route_src), j % 2);
    end
    req_valid = '0;

    // rejected job from source 1 (mix=7)
    do_reset();
    req_mix = {3'd7, 3'd0};
    req_valid = 2'b10;
    #1;
    chk("t3_ready", 32'(req_ready), 2);
    tick();
    req_valid = '0;
    chk("t3_done", 32'(done), 1);
    chk("t3_done_err", 32'(done_err), 1);
    chk("t3_done_id", 32'(done_id), 1);
    chk("t3_cfg_valid", 32'(cfg_valid), 0);
    chk("t3_flow_en", 32'(flow_en), 0);
    chk("t3_flush_en", 32'(flush_en), 0);
    tick();
    chk("t3_done_clear", 32'(done), 0);
    chk("t3_cfg_still_0", 32'(cfg_valid), 0);
    req_mix = {3'd0, 3'd3};
    req_heat = 2'b01;
    req_filt = 2'b01;
    req_valid = 2'b01;
    #1;
    chk("t3_next_accept", 32'(req_ready), 1);

    // reset asserted during FLOW aborts the job
    tick();
    req_valid = '0;
    chk("t4_mix", 32'(mix_sel), 3);
    for (int c = 2; c <= S + 3; c++) tick();
    chk("t4_in_flow", 32'(flow_en), 1);
    rst = 1'b1;
    tick();
    chk("t4_cfg_valid", 32'(cfg_valid), 0);
    chk("t4_flow_en", 32'(flow_en), 0);
    chk("t4_flush_en", 32'(flush_en), 0);
    chk("t4_done", 32'(done), 0);
    chk("t4_done_id", 32'(done_id), 0);
    chk("t4_done_err", 32'(done_err), 0);
    chk("t4_route", 32'(route_src), 0);
    chk("t4_mix_rst", 32'(mix_sel), 0);
    chk("t4_heat_rst", 32'(heat_sel), 0);
    chk("t4_filt_rst", 32'(filt_sel), 0);
    rst = 1'b0;
    req_mix = {3'd4, 3'd0};
    req_heat = 2'b10;
    req_filt = 2'b00;
    req_valid = 2'b10;
    #1;
    chk("t4_fresh_ready", 32'(req_ready), 2);
    for (int c = 1; c <= JOB; c++) begin
      tick();
      if (c == 1) begin
        req_valid = '0;
        chk("t4_fresh_route", 32'(route_src), 1);
        chk("t4_fresh_mix", 32'(mix_sel), 4);
        chk("t4_fresh_heat", 32'(heat_sel), 1);
      end
      chk("t4_fresh_done", 32'(done), 32'(c == JOB));
    end
    chk("t4_fresh_done_id", 32'(done_id), 1);

    // request arriving during an active job waits for IDLE
    do_reset();
    req_mix = {3'd4, 3'd1};
    req_heat = 2'b10;
    req_filt = 2'b10;
    req_valid = 2'b01;
    #1;
    chk("t6_first_ready", 32'(req_ready), 1);
    tick();
    chk("t6_first_mix", 32'(mix_sel), 1);
    chk("t6_first_heat", 32'(heat_sel), 0);
    req_valid = 2'b10;
    #1;
    for (int c = 1; c <= JOB; c++) begin
      chk("t6_ready_held_0", 32'(req_ready), 0);
      tick();
    end
    chk("t6_late_ready", 32'(req_ready), 2);
    tick();
    req_valid = '0;
    chk("t6_route", 32'(route_src), 1);
    chk("t6_mix", 32'(mix_sel), 4);
    chk("t6_heat", 32'(heat_sel), 1);
    chk("t6_filt", 32'(filt_sel), 1);
    chk("t6_cfg_valid", 32'(cfg_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
